// File: rtl/root_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : root_sched_pkg
// Description : Shared types and widths for the root request scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package root_sched_pkg;

    // Engine operand and result widths
    localparam int RAD_W  = 10;
    localparam int EXP_W  = 3;
    localparam int RES_W  = 20;
    localparam int FRAC_W = 10;

    // Scheduler states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        FLUSH = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/root_req_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches upward from the
//               pointer with wrap-around and returns the first requester.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_req
);

    logic [ID_W-1:0] w_idx;
    logic            w_found;

    // Walk the requesters starting at ptr; the first active one wins
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any_req      = |req;
        w_found      = 1'b0;
        w_idx        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = ID_W'((int'(ptr) + i) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found             = 1'b1;
                grant_onehot[w_idx] = 1'b1;
                grant_idx           = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/root_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : root_req_scheduler
// Description : Shares one iterative root engine among N_REQ requesters with
//               round-robin arbitration, operand holding, a watchdog that
//               flushes a hung engine, and a tagged response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module root_req_scheduler
    import root_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int TIMEOUT      = 1024,
    parameter int FLUSH_CYCLES = 2,
    parameter int ID_W         = 2      // must equal clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*RAD_W-1:0] req_data_1,
    input  logic [N_REQ*EXP_W-1:0] req_data_2,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [RES_W-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   eng_in_valid,
    output logic [RAD_W-1:0]       eng_in_data_1,
    output logic [EXP_W-1:0]       eng_in_data_2,
    input  logic                   eng_out_valid,
    input  logic [RES_W-1:0]       eng_out_data,
    output logic                   eng_rst_n
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_rsp_id;
    logic [RES_W-1:0]   r_rsp_data;
    logic               r_rsp_err;
    logic               r_rsp_valid;
    logic               r_eng_in_valid;
    logic [RAD_W-1:0]   r_eng_d1;
    logic [EXP_W-1:0]   r_eng_d2;
    logic [WD_W-1:0]    r_wdog;
    logic [FC_W-1:0]    r_flush_cnt;

    logic [N_REQ-1:0]   w_gnt_onehot;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_any_req;
    logic [RAD_W-1:0]   w_sel_d1;
    logic [EXP_W-1:0]   w_sel_d2;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req          (req_valid),
        .ptr          (r_rr_ptr),
        .grant_onehot (w_gnt_onehot),
        .grant_idx    (w_gnt_idx),
        .any_req      (w_any_req)
    );

    // Operand mux for the granted requester
    always_comb begin
        w_sel_d1 = '0;
        w_sel_d2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_onehot[i]) begin
                w_sel_d1 = req_data_1[i*RAD_W +: RAD_W];
                w_sel_d2 = req_data_2[i*EXP_W +: EXP_W];
            end
        end
    end

    assign req_ready     = (r_state == IDLE) ? w_gnt_onehot : '0;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_data      = r_rsp_data;
    assign rsp_err       = r_rsp_err;
    assign eng_in_valid  = r_eng_in_valid;
    assign eng_in_data_1 = r_eng_d1;
    assign eng_in_data_2 = r_eng_d2;
    // Engine is held in reset with the block and for the whole FLUSH state
    assign eng_rst_n     = rst_n & (r_state != FLUSH);

    // Main scheduler FSM with operand, response and watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_rr_ptr       <= '0;
            r_rsp_id       <= '0;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_eng_in_valid <= 1'b0;
            r_eng_d1       <= '0;
            r_eng_d2       <= '0;
            r_wdog         <= '0;
            r_flush_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_eng_d1 <= w_sel_d1;
                        r_eng_d2 <= w_sel_d2;
                        r_rsp_id <= w_gnt_idx;
                        if (w_sel_d2 == '0) begin
                            // Zero exponent is illegal: answer with an error, skip the engine
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end else begin
                            r_state        <= ISSUE;
                            r_eng_in_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    r_eng_in_valid <= 1'b0;
                    r_wdog         <= '0;
                    r_state        <= WAIT;
                end
                WAIT: begin
                    // WAIT spans TIMEOUT cycles (wdog 0..TIMEOUT-1); a result on the last one still wins
                    r_wdog <= r_wdog + 1'b1;
                    if (eng_out_valid) begin
                        r_rsp_data  <= eng_out_data;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                        r_flush_cnt <= '0;
                        r_state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt == FC_W'(FLUSH_CYCLES - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                        r_state     <= RESP;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                        r_rr_ptr    <= (r_rsp_id == ID_W'(N_REQ - 1)) ? '0 : r_rsp_id + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_root_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_root_req_scheduler
// Description : Directed self-checking bench for root_req_scheduler with a
//               small behavioural engine model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_root_req_scheduler;

    localparam int N   = 4;
    localparam int TO  = 64;
    localparam int FC  = 2;
    localparam int IDW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*10-1:0] req_data_1;
    logic [N*3-1:0]  req_data_2;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [19:0]   rsp_data;
    logic          rsp_err;
    logic          eng_in_valid;
    logic [9:0]    eng_in_data_1;
    logic [2:0]    eng_in_data_2;
    logic          eng_out_valid;
    logic [19:0]   eng_out_data;
    logic          eng_rst_n;

    // Engine model controls and outputs
    int            eng_lat;      // 0 = engine never answers
    int            eng_mode;     // 0 = fixed result, 1 = echo operands
    logic [19:0]   eng_fixed;
    logic          m_valid;
    logic [19:0]   m_data;
    int            m_cnt;
    logic          stray;

    int n_vec  = 0;
    int n_err  = 0;
    int n_issue = 0;
    int n_multi = 0;

    assign eng_out_valid = m_valid | stray;
    assign eng_out_data  = m_data;

    root_req_scheduler #(
        .N_REQ        (N),
        .TIMEOUT      (TO),
        .FLUSH_CYCLES (FC),
        .ID_W         (IDW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data_1    (req_data_1),
        .req_data_2    (req_data_2),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .eng_in_valid  (eng_in_valid),
        .eng_in_data_1 (eng_in_data_1),
        .eng_in_data_2 (eng_in_data_2),
        .eng_out_valid (eng_out_valid),
        .eng_out_data  (eng_out_data),
        .eng_rst_n     (eng_rst_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (eng_in_valid) n_issue <= n_issue + 1;
    always @(negedge clk) if ($countones(req_ready) > 1) n_multi <= n_multi + 1;

    // Engine model: strobes eng_lat cycles after the start pulse
    initial begin
        m_valid = 1'b0;
        m_data  = '0;
        m_cnt   = 0;
        forever begin
            @(negedge clk);
            m_valid = 1'b0;
            if (!eng_rst_n) begin
                m_cnt = 0;
            end else begin
                if (m_cnt > 0) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_valid = 1'b1;
                        m_data  = (eng_mode == 1) ? {7'd0, eng_in_data_2, eng_in_data_1} : eng_fixed;
                    end
                end
                if (eng_in_valid && eng_lat > 0) m_cnt = eng_lat;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [9:0] d1, input logic [2:0] d2);
        req_data_1[i*10 +: 10] = d1;
        req_data_2[i*3 +: 3]   = d2;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        stray     = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(input int budget, output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < budget) begin
            step();
            cyc++;
        end
        if (!rsp_valid) check_eq("rsp_wait_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got stuck, want finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int bad;
        int low;
        int base;
        int g;
        logic [19:0] e;

        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_data_1 = '0; req_data_2 = '0; stray = 1'b0;
        eng_lat = 0; eng_mode = 0; eng_fixed = '0;
        repeat (2) step();

        // Reset values
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_id", rsp_id, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_eng_in_valid", eng_in_valid, 0);
        check_eq("rst_eng_d1", eng_in_data_1, 0);
        check_eq("rst_eng_d2", eng_in_data_2, 0);
        check_eq("rst_eng_rst_n", eng_rst_n, 0);
        rst_n = 1'b1;
        #1 check_eq("rel_eng_rst_n", eng_rst_n, 1);
        step();

        // Single request 8^(1/3) -> 2.0 = 0x00800, engine latency 40
        eng_mode = 0; eng_fixed = 20'h00800; eng_lat = 40;
        set_req(0, 10'd8, 3'd3);
        req_valid = 4'b0001;
        #1 check_eq("t1_ready", req_ready, 4'b0001);
        base = n_issue;
        step();
        req_valid = '0;
        check_eq("t1_issue", eng_in_valid, 1);
        check_eq("t1_op1", eng_in_data_1, 8);
        check_eq("t1_op2", eng_in_data_2, 3);
        cyc = 0; bad = 0;
        while (!rsp_valid && cyc < 100) begin
            step();
            cyc++;
            if (eng_in_data_1 !== 10'd8 || eng_in_data_2 !== 3'd3 || (cyc > 0 && eng_in_valid)) bad++;
        end
        check_eq("t1_latency", cyc, 41);
        check_eq("t1_hold", bad, 0);
        check_eq("t1_rsp_id", rsp_id, 0);
        check_eq("t1_rsp_data", rsp_data, 20'h00800);
        check_eq("t1_rsp_err", rsp_err, 0);
        check_eq("t1_one_pulse", n_issue - base, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq("t1_done", rsp_valid, 0);

        // All requesters continuously valid: grants 0,1,2,3,0
        do_reset();
        eng_mode = 1; eng_lat = 3;
        for (int i = 0; i < N; i++) set_req(i, 10'(100 + i), 3'(i + 1));
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            g = k % N;
            cyc = 0;
            while (req_ready == '0 && cyc < 20) begin
                step();
                cyc++;
            end
            check_eq("t2_grant", req_ready, 32'd1 << g);
            step();
            wait_rsp(20, cyc);
            e = {7'd0, 3'(g + 1), 10'(100 + g)};
            check_eq("t2_rsp_id", rsp_id, g);
            check_eq("t2_rsp_data", rsp_data, e);
            check_eq("t2_no_grant_hs", req_ready, 0);
            if (k == 4) req_valid = '0;
            step();
        end
        rsp_ready = 1'b0;

        // Illegal exponent on req2 (pointer is at 1)
        set_req(2, 10'd50, 3'd0);
        req_valid = 4'b0100;
        #1 check_eq("t3_ready", req_ready, 4'b0100);
        base = n_issue;
        step();
        req_valid = '0;
        check_eq("t3_rsp_valid", rsp_valid, 1);
        check_eq("t3_rsp_id", rsp_id, 2);
        check_eq("t3_rsp_err", rsp_err, 1);
        check_eq("t3_rsp_data", rsp_data, 0);
        check_eq("t3_ready_drop", req_ready, 0);
        check_eq("t3_no_start", eng_in_valid, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq("t3_no_issue", n_issue - base, 0);
        check_eq("t3_done", rsp_valid, 0);

        // Timeout: engine never answers
        eng_lat = 0;
        set_req(3, 10'd27, 3'd3);
        req_valid = 4'b1000;
        #1 check_eq("t4_ready", req_ready, 4'b1000);
        step();
        req_valid = '0;
        check_eq("t4_issue", eng_in_valid, 1);
        cyc = 0; bad = 0;
        while (eng_rst_n && cyc < 200) begin
            step();
            cyc++;
            if (rsp_valid) bad++;
        end
        check_eq("t4_flush_at", cyc, TO + 1);
        check_eq("t4_no_early_rsp", bad, 0);
        low = 0;
        while (!eng_rst_n && low < 10) begin
            low++;
            step();
        end
        check_eq("t4_flush_len", low, FC);
        check_eq("t4_rsp_valid", rsp_valid, 1);
        check_eq("t4_rsp_id", rsp_id, 3);
        check_eq("t4_rsp_err", rsp_err, 1);
        check_eq("t4_rsp_data", rsp_data, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        eng_mode = 0; eng_fixed = 20'h00800; eng_lat = 5;
        set_req(0, 10'd8, 3'd3);
        req_valid = 4'b0001;
        #1 check_eq("t4b_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        wait_rsp(20, cyc);
        check_eq("t4b_latency", cyc, 6);
        check_eq("t4b_rsp_data", rsp_data, 20'h00800);
        check_eq("t4b_rsp_err", rsp_err, 0);
        check_eq("t4b_rsp_id", rsp_id, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Backpressure with req1 pending
        do_reset();
        eng_lat = 2;
        set_req(0, 10'd8, 3'd3);
        set_req(1, 10'd64, 3'd2);
        req_valid = 4'b0011;
        #1 check_eq("t5_ready", req_ready, 4'b0001);
        step();
        req_valid = 4'b0010;
        wait_rsp(20, cyc);
        bad = 0;
        for (int j = 0; j < 5; j++) begin
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 20'h00800 ||
                rsp_err !== 1'b0 || req_ready !== 4'b0000) bad++;
            step();
        end
        check_eq("t5_stable", bad, 0);
        rsp_ready = 1'b1;
        check_eq("t5_hs_no_grant", req_ready, 0);
        step();
        rsp_ready = 1'b0;
        check_eq("t5_next_grant", req_ready, 4'b0010);
        step();
        req_valid = '0;
        wait_rsp(20, cyc);
        check_eq("t5b_rsp_id", rsp_id, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset during WAIT
        eng_lat = 0;
        set_req(2, 10'd8, 3'd3);
        req_valid = 4'b0100;
        #1 check_eq("t6_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_eq("t6_eng_rst_n", eng_rst_n, 0);
        check_eq("t6_rsp_valid", rsp_valid, 0);
        check_eq("t6_eng_d1", eng_in_data_1, 0);
        check_eq("t6_eng_d2", eng_in_data_2, 0);
        check_eq("t6_req_ready", req_ready, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        stray = 1'b1;
        step();
        stray = 1'b0;
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (rsp_valid || eng_in_valid || req_ready != '0) bad++;
        end
        check_eq("t6_quiet", bad, 0);
        check_eq("t6_rsp_data", rsp_data, 0);

        check_eq("onehot_ready", n_multi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/root_req_scheduler.md
Name: root_req_scheduler

Overview:
- Shares one root engine among N_REQ independent requesters.
- The engine is a 10-bit radicand, 3-bit exponent iterative root unit. It takes a one-cycle start pulse, needs its operands held stable until it asserts a one-cycle result strobe, and returns a 20-bit fixed-point result (10 fractional bits).
- This block does round-robin arbitration, operand latching and holding, engine start sequencing, a watchdog timeout with engine flush, and a tagged response channel with backpressure.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, maximum cycles in WAIT before the engine is flushed.
- FLUSH_CYCLES, 2, cycles eng_rst_n is held low on a flush.
- ID_W, 2, requester id width; must equal clog2(N_REQ).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept, one-hot or zero.
- req_data_1  in  N_REQ*10  radicands, requester i at bits [10i+9:10i].
- req_data_2  in  N_REQ*3  exponents, requester i at bits [3i+2:3i].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester the response belongs to.
- rsp_data  out  20  root result.
- rsp_err  out  1  1 = timeout or illegal exponent; rsp_data is then 0.
- eng_in_valid  out  1  engine start pulse.
- eng_in_data_1  out  10  engine radicand, held stable.
- eng_in_data_2  out  3  engine exponent, held stable.
- eng_out_valid  in  1  engine result strobe.
- eng_out_data  in  20  engine result.
- eng_rst_n  out  1  engine reset, active-low: rst_n AND NOT flush_active.

Behaviour:
Reset and clocking:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, eng_in_valid=0, eng_in_data_1=0, eng_in_data_2=0, wdog=0, eng_rst_n=0 while rst_n is low.
- Reset asserted mid-operation abandons the transaction. No response is produced and the engine is reset with the block.

Arbitration:
- Round-robin, searching upward from rr_ptr with wrap-around.
- req_ready[g] is combinational and equals (state==IDLE) && grant_onehot[g].
- A request is accepted when req_valid[g] && req_ready[g].
- After a response handshake, rr_ptr = (g+1) mod N_REQ. rr_ptr does not move otherwise.

State machine (registered state):
- IDLE: if any req_valid, accept grant g and latch data_1[g], data_2[g] and id=g.
  - If data_2==0, go to RESP with rsp_err=1, rsp_data=0; the engine is not started.
  - Otherwise go to ISSUE.
- ISSUE: eng_in_valid=1 for exactly this cycle; clear wdog; go to WAIT.
- WAIT: wdog increments each cycle.
  - On eng_out_valid: capture eng_out_data into rsp_data, rsp_err=0, go to RESP.
  - Else if wdog==TIMEOUT-1: go to FLUSH.
  - eng_out_valid and timeout in the same cycle: the result wins.
- FLUSH: eng_rst_n=0 for FLUSH_CYCLES cycles, then go to RESP with rsp_err=1, rsp_data=0.
- RESP: rsp_valid=1 with rsp_id, rsp_data and rsp_err stable until rsp_ready. The handshake cycle returns to IDLE.
  - No new grant in the handshake cycle; the earliest next accept is the following cycle.

Datapath rules:
- eng_in_data_1 and eng_in_data_2 hold the latched operands from ISSUE through the end of WAIT. They change only on an accept.
- eng_out_valid outside WAIT is ignored; no state change.
- req_valid deasserting while not granted is legal.

Latency:
- Accept at cycle T, eng_in_valid at T+1.
- Engine strobe at T+1+L gives rsp_valid from T+2+L.
- Illegal exponent gives rsp_valid at T+1.

Decomposition:
- Package root_sched_pkg:
  - state enum {IDLE, ISSUE, WAIT, FLUSH, RESP};
  - constants RAD_W=10, EXP_W=3, RES_W=20, FRAC_W=10.
- Sub-module rr_arbiter (N_REQ): inputs req vector and rr_ptr; outputs grant_onehot, grant_idx and any_req. Purely combinational.
- FSM, operand and response registers, and the watchdog stay in root_req_scheduler.

Test Plan:
- Single request, req0 data_1=8, data_2=3, engine model replies 0x00800 after 40 cycles -> exactly one eng_in_valid pulse; operands 8/3 held throughout WAIT; rsp_id=0, rsp_data=0x00800, rsp_err=0.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; rr_ptr wraps; never two req_ready bits high.
- req2 with data_2=0 -> req_ready[2] for one cycle; no eng_in_valid; rsp_valid next cycle with rsp_id=2, rsp_err=1, rsp_data=0.
- TIMEOUT=64, engine never responds -> FLUSH entered 64 cycles after ISSUE; eng_rst_n low for 2 cycles; rsp_err=1, rsp_data=0; the next request is served normally.
- rsp_ready low for 5 cycles with req1 also pending -> rsp_* stable, req_ready all 0; after the handshake, req1 is granted the following cycle.
- rst_n pulsed low during WAIT -> all outputs at reset values immediately; no rsp_valid for the abandoned request; a stray eng_out_valid after reset is ignored.
